nts_dispatcher_rr: RTL and testbench

//  Multi-engine successor to the single-engine NTS RX dispatcher. Captures MAC RX frames (64-bit words, per-byte valid)

---
 rtl/nts_dispatcher_rr.sv | 221 ++++++++++++++++++++++
 tb/tb_nts_dispatcher_rr.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nts_dispatcher_rr.sv
// rtl/nts_dispatcher_rr.sv - MAC RX frame capture into ping-pong buffers, round-robin grant to NTS engines
module nts_dispatcher_rr #(
    parameter int ENGINES    = 4,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [63:0]           i_ntp_time,
    input  logic [7:0]            i_rx_data_valid,
    input  logic [63:0]           i_rx_data,
    input  logic                  i_rx_bad_frame,
    input  logic                  i_rx_good_frame,
    input  logic [ENGINES-1:0]    i_dispatch_busy,
    output logic [ENGINES-1:0]    o_dispatch_packet_available,
    input  logic [ENGINES-1:0]    i_dispatch_packet_read_discard,
    input  logic [ENGINES-1:0]    i_dispatch_fifo_rd_start,
    output logic                  o_dispatch_fifo_rd_valid,
    output logic [63:0]           o_dispatch_fifo_rd_data,
    output logic                  o_dispatch_fifo_empty,
    output logic [ADDR_WIDTH:0]   o_dispatch_counter,
    output logic [3:0]            o_dispatch_data_valid,
    output logic [63:0]           o_dispatch_timestamp,
    output logic [31:0]           o_cnt_good,
    output logic [31:0]           o_cnt_bad,
    output logic [31:0]           o_cnt_drop
);

    localparam int EW    = (ENGINES > 1) ? $clog2(ENGINES) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILLING, BUF_READY, BUF_GRANTED} buf_state_t;

    buf_state_t          buf_st  [2];
    logic [ADDR_WIDTH:0] buf_cnt [2];
    logic [3:0]          buf_dv  [2];
    logic [63:0]         buf_ts  [2];
    logic                buf_seq [2];
    logic                wr_seq;

    logic                in_frame, wr_buf, wr_drop, wr_ovf;
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [3:0]          last_dv;

    logic [63:0]         mem [2*DEPTH];
    logic [63:0]         rd_q;

    logic [EW-1:0]         g_eng, rr_ptr, sel_eng, sel_next;
    logic                  gnt_buf, streaming, sel_found;
    logic [ADDR_WIDTH-1:0] rd_addr;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    logic                has_word, eof, starting, active, cur_buf, cur_drop;
    logic                do_write, ovf_now, accept, frame_has_buf;
    logic [ADDR_WIDTH:0] cur_ptr, words;
    logic [3:0]          dv_now;

    assign has_word      = |i_rx_data_valid;
    assign eof           = i_rx_good_frame | i_rx_bad_frame;
    assign starting      = !in_frame && has_word;
    assign active        = in_frame || starting;
    assign cur_buf       = in_frame ? wr_buf  : (buf_st[0] != BUF_EMPTY);
    assign cur_drop      = in_frame ? wr_drop : (buf_st[0] != BUF_EMPTY && buf_st[1] != BUF_EMPTY);
    assign cur_ptr       = in_frame ? wr_ptr  : '0;
    assign frame_has_buf = active && !cur_drop;
    // The pointer parks at DEPTH once full; any further word marks the frame as overflowed.
    assign do_write      = frame_has_buf && has_word && !cur_ptr[ADDR_WIDTH];
    assign ovf_now       = (in_frame && wr_ovf) || (has_word && cur_ptr[ADDR_WIDTH]);
    assign words         = cur_ptr + (ADDR_WIDTH+1)'(has_word);
    assign accept        = i_rx_good_frame && !i_rx_bad_frame && frame_has_buf && !ovf_now;
    assign dv_now        = has_word ? popcount8(i_rx_data_valid) : last_dv;

    logic granted, ready0, ready1, has_ready, oldest, grant_now, discard_now, start_now, last_word;

    assign granted     = |o_dispatch_packet_available;
    assign ready0      = (buf_st[0] == BUF_READY);
    assign ready1      = (buf_st[1] == BUF_READY);
    assign has_ready   = ready0 | ready1;
    // With both buffers ready, the older one carries the sequence bit the next accept would get.
    assign oldest      = ready1 && (!ready0 || buf_seq[1] == wr_seq);
    assign grant_now   = !granted && has_ready && sel_found;
    assign discard_now = granted && i_dispatch_packet_read_discard[g_eng];
    assign start_now   = granted && !discard_now && i_dispatch_fifo_rd_start[g_eng]
                         && o_dispatch_fifo_empty && !o_dispatch_fifo_rd_valid;
    assign last_word   = ({1'b0, rd_addr} + (ADDR_WIDTH+1)'(1)) == o_dispatch_counter;
    assign sel_next    = (sel_eng == EW'(ENGINES-1)) ? '0 : sel_eng + EW'(1);

    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_eng   = '0;
        for (int i = 0; i < ENGINES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= ENGINES) idx = idx - ENGINES;
            if (!sel_found && !i_dispatch_busy[idx]) begin
                sel_found = 1'b1;
                sel_eng   = EW'(idx);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            in_frame   <= 1'b0;
            wr_buf     <= 1'b0;
            wr_drop    <= 1'b0;
            wr_ovf     <= 1'b0;
            wr_ptr     <= '0;
            last_dv    <= '0;
            wr_seq     <= 1'b0;
            o_cnt_good <= '0;
            o_cnt_bad  <= '0;
            o_cnt_drop <= '0;
            for (int b = 0; b < 2; b++) begin
                buf_st[b]  <= BUF_EMPTY;
                buf_cnt[b] <= '0;
                buf_dv[b]  <= '0;
                buf_ts[b]  <= '0;
                buf_seq[b] <= 1'b0;
            end
        end else begin
            if (eof) begin
                in_frame <= 1'b0;
            end else if (starting) begin
                in_frame <= 1'b1;
                wr_buf   <= cur_buf;
                wr_drop  <= cur_drop;
            end
            if (active) begin
                wr_ptr <= do_write ? cur_ptr + (ADDR_WIDTH+1)'(1) : cur_ptr;
                wr_ovf <= ovf_now;
                if (has_word) last_dv <= popcount8(i_rx_data_valid);
            end
            if (i_rx_bad_frame)       o_cnt_bad  <= o_cnt_bad + 32'd1;
            else if (accept)          o_cnt_good <= o_cnt_good + 32'd1;
            else if (i_rx_good_frame) o_cnt_drop <= o_cnt_drop + 32'd1;
            if (accept) wr_seq <= ~wr_seq;

            // Write side only touches EMPTY/FILLING buffers, grant side only READY/GRANTED ones.
            for (int b = 0; b < 2; b++) begin
                if (eof && frame_has_buf && cur_buf == 1'(b)) begin
                    if (accept) begin
                        buf_st[b]  <= BUF_READY;
                        buf_cnt[b] <= words;
                        buf_dv[b]  <= dv_now;
                        buf_seq[b] <= wr_seq;
                    end else begin
                        buf_st[b] <= BUF_EMPTY;
                    end
                end else if (starting && !cur_drop && cur_buf == 1'(b)) begin
                    buf_st[b] <= BUF_FILLING;
                end else if (grant_now && oldest == 1'(b)) begin
                    buf_st[b] <= BUF_GRANTED;
                end else if (discard_now && gnt_buf == 1'(b)) begin
                    buf_st[b] <= BUF_EMPTY;
                end
                if (starting && !cur_drop && cur_buf == 1'(b)) buf_ts[b] <= i_ntp_time;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_dispatch_packet_available <= '0;
            g_eng                       <= '0;
            gnt_buf                     <= 1'b0;
            rr_ptr                      <= '0;
            streaming                   <= 1'b0;
            rd_addr                     <= '0;
            o_dispatch_fifo_rd_valid    <= 1'b0;
            o_dispatch_fifo_empty       <= 1'b1;
            o_dispatch_counter          <= '0;
            o_dispatch_data_valid       <= '0;
            o_dispatch_timestamp        <= '0;
        end else if (discard_now) begin
            o_dispatch_packet_available <= '0;
            streaming                   <= 1'b0;
            o_dispatch_fifo_rd_valid    <= 1'b0;
            o_dispatch_fifo_empty       <= 1'b1;
            o_dispatch_counter          <= '0;
            o_dispatch_data_valid       <= '0;
            o_dispatch_timestamp        <= '0;
        end else begin
            o_dispatch_fifo_rd_valid <= streaming;
            if (grant_now) begin
                o_dispatch_packet_available          <= '0;
                o_dispatch_packet_available[sel_eng] <= 1'b1;
                g_eng                                <= sel_eng;
                gnt_buf                              <= oldest;
                rr_ptr                               <= sel_next;
                o_dispatch_counter                   <= buf_cnt[oldest];
                o_dispatch_data_valid                <= buf_dv[oldest];
                o_dispatch_timestamp                 <= buf_ts[oldest];
            end
            if (start_now) begin
                streaming             <= 1'b1;
                rd_addr               <= '0;
                o_dispatch_fifo_empty <= 1'b0;
            end else if (streaming) begin
                rd_addr <= rd_addr + ADDR_WIDTH'(1);
                if (last_word) streaming <= 1'b0;
            end else if (o_dispatch_fifo_rd_valid) begin
                o_dispatch_fifo_empty <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_write) mem[{cur_buf, cur_ptr[ADDR_WIDTH-1:0]}] <= i_rx_data;
        rd_q <= mem[{gnt_buf, rd_addr}];
    end

    assign o_dispatch_fifo_rd_data = o_dispatch_fifo_rd_valid ? rd_q : '0;

endmodule

// File: tb/tb_nts_dispatcher_rr.sv
// tb/tb_nts_dispatcher_rr.sv - self-checking bench for nts_dispatcher_rr
module tb_nts_dispatcher_rr;
    localparam int ENG   = 4;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            areset;
    logic [63:0]     ntp;
    logic [7:0]      rx_valid;
    logic [63:0]     rx_data;
    logic            rx_bad, rx_good;
    logic [ENG-1:0]  busy, discard, rd_start, avail;
    logic            rd_valid, fifo_empty;
    logic [63:0]     rd_data, ts_out;
    logic [AW:0]     counter;
    logic [3:0]      dv_out;
    logic [31:0]     cnt_good, cnt_bad, cnt_drop;

    nts_dispatcher_rr #(.ENGINES(ENG), .ADDR_WIDTH(AW)) dut (
        .i_clk                          (clk),
        .i_areset                       (areset),
        .i_ntp_time                     (ntp),
        .i_rx_data_valid                (rx_valid),
        .i_rx_data                      (rx_data),
        .i_rx_bad_frame                 (rx_bad),
        .i_rx_good_frame                (rx_good),
        .i_dispatch_busy                (busy),
        .o_dispatch_packet_available    (avail),
        .i_dispatch_packet_read_discard (discard),
        .i_dispatch_fifo_rd_start       (rd_start),
        .o_dispatch_fifo_rd_valid       (rd_valid),
        .o_dispatch_fifo_rd_data        (rd_data),
        .o_dispatch_fifo_empty          (fifo_empty),
        .o_dispatch_counter             (counter),
        .o_dispatch_data_valid          (dv_out),
        .o_dispatch_timestamp           (ts_out),
        .o_cnt_good                     (cnt_good),
        .o_cnt_bad                      (cnt_bad),
        .o_cnt_drop                     (cnt_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: FIFO of accepted frames, buffers held, next engine to try, expected counters.
    logic [63:0] q_data[$];
    int          q_len[$];
    logic [3:0]  q_dv[$];
    logic [63:0] q_ts[$];
    int          outstanding;
    int          rr_next;
    logic [31:0] e_good, e_bad, e_drop;

    task automatic tick();
        @(posedge clk);
        #1;
        ntp = ntp + 64'd3;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_eng(input logic [ENG-1:0] b);
        for (int i = 0; i < ENG; i++) begin
            int e = (rr_next + i) % ENG;
            if (!b[e]) return e;
        end
        return -1;
    endfunction

    task automatic clear_model();
        q_data.delete(); q_len.delete(); q_dv.delete(); q_ts.delete();
        outstanding = 0;
        rr_next     = 0;
        e_good      = 0;
        e_bad       = 0;
        e_drop      = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        tick();
        clear_model();
    endtask

    task automatic send_frame(input int n, input logic [7:0] lastv, input bit bad);
        logic [63:0] words[$];
        logic [63:0] w, ts;
        bit          acc;
        acc = !bad && n <= DEPTH && outstanding < 2;
        ts  = '0;
        for (int k = 0; k < n; k++) begin
            w = {$urandom, $urandom};
            words.push_back(w);
            if (k == 0) ts = ntp;
            rx_data  = w;
            rx_valid = (k == n - 1) ? lastv : 8'hff;
            rx_good  = (k == n - 1) && !bad;
            rx_bad   = (k == n - 1) && bad;
            tick();
        end
        rx_valid = '0; rx_good = 1'b0; rx_bad = 1'b0; rx_data = '0;
        if (bad) begin
            e_bad++;
        end else if (acc) begin
            e_good++;
            outstanding++;
            q_len.push_back(n);
            q_dv.push_back(4'($countones(lastv)));
            q_ts.push_back(ts);
            foreach (words[i]) q_data.push_back(words[i]);
        end else begin
            e_drop++;
        end
    endtask

    task automatic await_grant(input string tag, output int e, output int n);
        int waited = 0;
        while (avail == '0 && waited < 300) begin
            tick();
            waited++;
        end
        e = -1;
        n = q_len.pop_front();
        chk({tag, "_grant_seen"}, 64'(avail != '0), 64'd1);
        if (avail != '0) begin
            e = pick_eng(busy);
            rr_next = (e + 1) % ENG;
            chk({tag, "_avail"}, 64'(avail), 64'd1 << e);
            chk({tag, "_counter"}, 64'(counter), 64'(n));
            chk({tag, "_data_valid"}, 64'(dv_out), 64'(q_dv.pop_front()));
            chk({tag, "_timestamp"}, ts_out, q_ts.pop_front());
        end else begin
            void'(q_dv.pop_front());
            void'(q_ts.pop_front());
            for (int k = 0; k < n; k++) void'(q_data.pop_front());
            outstanding--;
        end
    endtask

    task automatic service(input string tag);
        int e, n;
        await_grant(tag, e, n);
        if (e < 0) return;
        rd_start[e] = 1'b1;
        tick();
        rd_start = '0;
        chk({tag, "_empty_low"}, 64'(fifo_empty), 64'd0);
        chk({tag, "_no_early_valid"}, 64'(rd_valid), 64'd0);
        tick();
        for (int k = 0; k < n; k++) begin
            chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd1);
            chk({tag, "_rd_data"}, rd_data, q_data.pop_front());
            tick();
        end
        chk({tag, "_valid_end"}, 64'(rd_valid), 64'd0);
        chk({tag, "_empty_end"}, 64'(fifo_empty), 64'd1);
        discard[e] = 1'b1;
        tick();
        discard = '0;
        chk({tag, "_avail_drop"}, 64'(avail), 64'd0);
        outstanding--;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_cnt_good"}, 64'(cnt_good), 64'(e_good));
        chk({tag, "_cnt_bad"},  64'(cnt_bad),  64'(e_bad));
        chk({tag, "_cnt_drop"}, 64'(cnt_drop), 64'(e_drop));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_avail"},    64'(avail),      64'd0);
        chk({tag, "_empty"},    64'(fifo_empty), 64'd1);
        chk({tag, "_rd_valid"}, 64'(rd_valid),   64'd0);
        chk({tag, "_rd_data"},  rd_data,         64'd0);
        chk({tag, "_counter"},  64'(counter),    64'd0);
        chk({tag, "_dv"},       64'(dv_out),     64'd0);
        chk({tag, "_ts"},       ts_out,          64'd0);
        chk({tag, "_good"},     64'(cnt_good),   64'd0);
        chk({tag, "_bad"},      64'(cnt_bad),    64'd0);
        chk({tag, "_drop"},     64'(cnt_drop),   64'd0);
    endtask

    initial begin
        int          e, n;
        logic [63:0] w;
        areset = 1'b1; ntp = 64'h0123_4567_0000_0000;
        rx_valid = '0; rx_data = '0; rx_bad = 1'b0; rx_good = 1'b0;
        busy = '0; discard = '0; rd_start = '0;
        clear_model();
        tick();
        tick();
        check_reset_outputs("reset");
        areset = 1'b0;
        tick();

        // Single 29-word frame, last word 7 bytes
        send_frame(29, 8'h7f, 1'b0);
        service("t1");
        check_counters("t1");

        // Four frames, all engines idle: engines 0..3
        do_reset();
        send_frame(int'($urandom_range(1, 40)), 8'hff, 1'b0);
        send_frame(int'($urandom_range(1, 40)), 8'h03, 1'b0);
        service("t2a");
        service("t2b");
        send_frame(int'($urandom_range(1, 40)), 8'h01, 1'b0);
        send_frame(int'($urandom_range(1, 40)), 8'h3f, 1'b0);
        service("t2c");
        service("t2d");
        check_counters("t2");

        // Engine 1 busy after a grant to engine 0
        do_reset();
        send_frame(12, 8'hff, 1'b0);
        service("t3a");
        busy = 4'b0010;
        send_frame(9, 8'h0f, 1'b0);
        service("t3b");
        send_frame(7, 8'h07, 1'b0);
        service("t3c");
        busy = '0;

        // Three frames with no discard: third dropped
        do_reset();
        send_frame(5, 8'hff, 1'b0);
        send_frame(6, 8'h1f, 1'b0);
        send_frame(4, 8'hff, 1'b0);
        check_counters("t4");
        service("t4a");
        service("t4b");

        // Size boundary and bad frame
        do_reset();
        send_frame(DEPTH, 8'h80, 1'b0);
        service("t5a");
        send_frame(DEPTH + 1, 8'hff, 1'b0);
        send_frame(10, 8'hff, 1'b1);
        check_counters("t5");
        send_frame(3, 8'h0f, 1'b0);
        service("t5b");

        // Randomized lengths, byte enables and busy masks
        for (int it = 0; it < 6; it++) begin
            busy = ENG'($urandom);
            if (&busy) busy[$urandom_range(0, ENG - 1)] = 1'b0;
            send_frame((it == 5) ? DEPTH : int'($urandom_range(1, 40)), 8'($urandom_range(1, 255)), 1'b0);
            service("rnd");
            busy = '0;
        end
        check_counters("rnd");

        // Discard mid-stream, then the queued frame follows
        do_reset();
        send_frame(20, 8'hff, 1'b0);
        send_frame(10, 8'h0f, 1'b0);
        await_grant("t6a", e, n);
        if (e >= 0) begin
            rd_start[e] = 1'b1;
            tick();
            rd_start = '0;
            tick();
            for (int k = 0; k < 5; k++) begin
                w = q_data.pop_front();
                chk("t6_rd_valid", 64'(rd_valid), 64'd1);
                chk("t6_rd_data", rd_data, w);
                tick();
            end
            discard[e] = 1'b1;
            tick();
            discard = '0;
            chk("t6_abort_valid", 64'(rd_valid), 64'd0);
            chk("t6_abort_empty", 64'(fifo_empty), 64'd1);
            chk("t6_abort_avail", 64'(avail), 64'd0);
            for (int k = 5; k < n; k++) void'(q_data.pop_front());
            outstanding--;
        end
        service("t6b");

        // Reset while a grant is outstanding and a frame is arriving
        send_frame(8, 8'hff, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rx_valid = 8'hff;
            rx_data  = {$urandom, $urandom};
            tick();
        end
        chk("t6_pre_reset_avail", 64'(avail != '0), 64'd1);
        areset = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        rx_valid = '0;
        rx_data  = '0;
        tick();
        areset = 1'b0;
        tick();
        clear_model();
        send_frame(4, 8'h03, 1'b0);
        service("t6c");
        check_counters("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
